// File: rtl/traffic_phase_ctrl.sv
// N-phase demand-actuated intersection controller: round-robin service with
// min/max green, emergency preemption and night flash; one lamp triple per phase.
module traffic_phase_ctrl #(
  parameter int NUM_PHASES  = 4,
  parameter int CNT_W       = 8,
  parameter int T_GREEN_MIN = 10,
  parameter int T_GREEN_MAX = 50,
  parameter int T_YELLOW    = 10,
  parameter int T_RED       = 5,
  parameter int T_FLASH     = 4,
  localparam int PH_W       = $clog2(NUM_PHASES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PHASES-1:0]   req,
  input  logic                    preempt,
  input  logic [PH_W-1:0]         preempt_phase,
  input  logic                    flash_mode,
  output logic [3*NUM_PHASES-1:0] lights,
  output logic [PH_W-1:0]         active_phase,
  output logic [1:0]              ctrl_state,
  output logic [NUM_PHASES-1:0]   pending
);

  typedef enum logic [1:0] {
    ST_GREEN   = 2'b00,
    ST_YELLOW  = 2'b01,
    ST_ALL_RED = 2'b10,
    ST_FLASH   = 2'b11
  } state_t;

  localparam logic [2:0] LAMP_OFF    = 3'b000;
  localparam logic [2:0] LAMP_RED    = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b100;

  localparam logic [CNT_W-1:0] GMIN_END  = CNT_W'(T_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_END  = CNT_W'(T_GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_END   = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] RED_END   = CNT_W'(T_RED - 1);
  localparam logic [CNT_W-1:0] FLASH_END = CNT_W'(T_FLASH - 1);

  state_t                  state_q, state_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [PH_W-1:0]         next_q, next_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        flash_cnt_q, flash_cnt_d;
  logic                    flash_on_q, flash_on_d;
  logic [NUM_PHASES-1:0]   pending_q, pending_d;

  logic [PH_W-1:0]         scan_idx;
  logic [PH_W-1:0]         scan_phase;
  logic                    scan_found;
  logic [NUM_PHASES-1:0]   green_mask;
  logic                    go_yellow;

  // Round-robin search: first pending phase strictly after the active one.
  // Finding one is exactly "another phase is waiting".
  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    scan_idx   = phase_q;
    scan_phase = phase_q;
    scan_found = 1'b0;
    for (int i = 1; i < NUM_PHASES; i++) begin
      scan_idx = PH_W'((int'(phase_q) + i) % NUM_PHASES);
      if (!scan_found && pending_q[scan_idx]) begin
        scan_phase = scan_idx;
        scan_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    next_d      = next_q;
    flash_on_d  = flash_on_q;
    flash_cnt_d = flash_cnt_q;
    go_yellow   = 1'b0;

    unique case (state_q)
      ST_GREEN: begin
        if (preempt) begin
          go_yellow = (preempt_phase != phase_q);
        end else if (flash_mode) begin
          go_yellow = (cnt_q >= GMIN_END);
        end else begin
          go_yellow = scan_found &&
                      ((cnt_q >= GMIN_END && !req[phase_q]) || cnt_q >= GMAX_END);
        end
        if (go_yellow) begin
          state_d = ST_YELLOW;
          next_d  = preempt ? preempt_phase : scan_phase;
        end
      end

      ST_YELLOW: begin
        if (cnt_q == YEL_END) state_d = ST_ALL_RED;
      end

      ST_ALL_RED: begin
        if (cnt_q == RED_END) begin
          if (preempt) begin
            state_d = ST_GREEN;
            phase_d = preempt_phase;
          end else if (flash_mode) begin
            state_d     = ST_FLASH;
            flash_on_d  = 1'b1;
            flash_cnt_d = '0;
          end else begin
            state_d = ST_GREEN;
            phase_d = next_q;
          end
        end
      end

      ST_FLASH: begin
        if (preempt || !flash_mode) begin
          // Leaving flash always restarts at phase 0 unless preempted.
          state_d = ST_ALL_RED;
          next_d  = '0;
        end else if (flash_cnt_q == FLASH_END) begin
          flash_on_d  = !flash_on_q;
          flash_cnt_d = '0;
        end else begin
          flash_cnt_d = flash_cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Demand latching; a phase entering green drops its own bit even if it is
  // requested in that same cycle.
  always_comb begin
    green_mask = '0;
    if (state_q == ST_GREEN) green_mask[phase_q] = 1'b1;
    pending_d = pending_q | (req & ~green_mask);
    if (state_d == ST_GREEN && (state_q != ST_GREEN || phase_d != phase_q))
      pending_d[phase_d] = 1'b0;
  end

  always_comb begin
    if (state_d != state_q || phase_d != phase_q) cnt_d = '0;
    else if (cnt_q == '1)                         cnt_d = cnt_q;
    else                                          cnt_d = cnt_q + 1'b1;
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_GREEN;
      phase_q     <= '0;
      next_q      <= '0;
      cnt_q       <= '0;
      flash_cnt_q <= '0;
      flash_on_q  <= 1'b1;
      pending_q   <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      next_q      <= next_d;
      cnt_q       <= cnt_d;
      flash_cnt_q <= flash_cnt_d;
      flash_on_q  <= flash_on_d;
      pending_q   <= pending_d;
    end
  end

  always_comb begin
    lights = '0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      if (state_q == ST_FLASH) begin
        if (!flash_on_q)  lights[3*p +: 3] = LAMP_OFF;
        else if (p == 0)  lights[3*p +: 3] = LAMP_YELLOW;
        else              lights[3*p +: 3] = LAMP_RED;
      end else if (PH_W'(p) == phase_q) begin
        if (state_q == ST_GREEN)       lights[3*p +: 3] = LAMP_GREEN;
        else if (state_q == ST_YELLOW) lights[3*p +: 3] = LAMP_YELLOW;
        else                           lights[3*p +: 3] = LAMP_RED;
      end else begin
        lights[3*p +: 3] = LAMP_RED;
      end
    end
  end

  assign active_phase = phase_q;
  assign ctrl_state   = state_q;
  assign pending      = pending_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed, table-driven bench for traffic_phase_ctrl (4 phases, default timing)
// with a free-running safety monitor on the lamp outputs.
module tb_traffic_phase_ctrl;

  localparam logic [1:0] S_G = 2'b00;
  localparam logic [1:0] S_Y = 2'b01;
  localparam logic [1:0] S_A = 2'b10;
  localparam logic [1:0] S_F = 2'b11;

  localparam logic [2:0] C_RED = 3'b001;
  localparam logic [2:0] C_YEL = 3'b010;
  localparam logic [2:0] C_GRN = 3'b100;

  localparam logic [11:0] L_ALL_RED   = 12'h249;
  localparam logic [11:0] L_FLASH_ON  = 12'h24A;
  localparam logic [11:0] L_FLASH_OFF = 12'h000;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic        preempt;
  logic [1:0]  preempt_phase;
  logic        flash_mode;
  logic [11:0] lights;
  logic [1:0]  active_phase;
  logic [1:0]  ctrl_state;
  logic [3:0]  pending;

  int checks   = 0;
  int failures = 0;

  traffic_phase_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .preempt       (preempt),
    .preempt_phase (preempt_phase),
    .flash_mode    (flash_mode),
    .lights        (lights),
    .active_phase  (active_phase),
    .ctrl_state    (ctrl_state),
    .pending       (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  req;
    logic        pre;
    logic [1:0]  pph;
    logic        flash;
    int          steps;
    logic [1:0]  st;
    logic [1:0]  ph;
    logic [11:0] lt;
    logic [3:0]  pend;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // All phases red except one phase showing the given colour.
  function automatic logic [11:0] lamps(input int ph, input logic [2:0] col);
    logic [11:0] l;
    l = {4{C_RED}};
    l[3*ph +: 3] = col;
    return l;
  endfunction

  function automatic void add(input string n, input logic r, input logic [3:0] rq,
                              input logic pre, input logic [1:0] pph, input logic fl,
                              input int steps, input logic [1:0] st, input logic [1:0] ph,
                              input logic [11:0] lt, input logic [3:0] pd);
    vec_t v;
    v.name = n; v.rst = r; v.req = rq; v.pre = pre; v.pph = pph; v.flash = fl;
    v.steps = steps; v.st = st; v.ph = ph; v.lt = lt; v.pend = pd;
    vecs.push_back(v);
  endfunction

  // Safety monitor, sampled on the falling edge.
  logic       rst_q;
  logic [1:0] mon_state;
  logic [1:0] mon_phase;
  int         run_len;

  always @(posedge clk) rst_q <= rst;

  always @(negedge clk) begin
    int non_red;
    if (rst_q !== 1'b1) begin
      run_len = 1;
    end else begin
      if (ctrl_state != S_F) begin
        non_red = 0;
        for (int p = 0; p < 4; p++) if (lights[3*p +: 3] != C_RED) non_red++;
        check("inv_one_non_red", 32'(non_red <= 1), 32'd1);
      end
      if (ctrl_state != mon_state) begin
        case (mon_state)
          S_G: check("inv_green_to_yellow", 32'(ctrl_state), 32'(S_Y));
          S_Y: begin
            check("inv_yellow_len", 32'(run_len), 32'd10);
            check("inv_yellow_to_allred", 32'(ctrl_state), 32'(S_A));
          end
          S_A: begin
            check("inv_allred_len", 32'(run_len), 32'd5);
            check("inv_allred_exit", 32'(ctrl_state == S_G || ctrl_state == S_F), 32'd1);
          end
          default: check("inv_flash_exit", 32'(ctrl_state), 32'(S_A));
        endcase
        run_len = 1;
      end else begin
        run_len++;
        if (ctrl_state == S_G)
          check("inv_green_phase_stable", 32'(active_phase), 32'(mon_phase));
      end
    end
    mon_state = ctrl_state;
    mon_phase = active_phase;
  end

  initial begin
    rst = 1'b0; req = '0; preempt = 1'b0; preempt_phase = '0; flash_mode = 1'b0;

    // Idle and a single remote request.
    add("t1_reset",        0, 4'b0000, 0, 0, 0,   1, S_G, 0, lamps(0, C_GRN), 4'b0000);
    add("t1_idle200",      1, 4'b0000, 0, 0, 0, 200, S_G, 0, lamps(0, C_GRN), 4'b0000);
    add("t2_reset",        0, 4'b0000, 0, 0, 0,   1, S_G, 0, lamps(0, C_GRN), 4'b0000);
    add("t2_pre",          1, 4'b0000, 0, 0, 0,   3, S_G, 0, lamps(0, C_GRN), 4'b0000);
    add("t2_req2",         1, 4'b0100, 0, 0, 0,   1, S_G, 0, lamps(0, C_GRN), 4'b0100);
    add("t2_min_end",      1, 4'b0000, 0, 0, 0,   5, S_G, 0, lamps(0, C_GRN), 4'b0100);
    add("t2_yellow",       1, 4'b0000, 0, 0, 0,   1, S_Y, 0, lamps(0, C_YEL), 4'b0100);
    add("t2_yellow_end",   1, 4'b0000, 0, 0, 0,   9, S_Y, 0, lamps(0, C_YEL), 4'b0100);
    add("t2_allred",       1, 4'b0000, 0, 0, 0,   1, S_A, 0, L_ALL_RED,       4'b0100);
    add("t2_allred_end",   1, 4'b0000, 0, 0, 0,   4, S_A, 0, L_ALL_RED,       4'b0100);
    add("t2_green2",       1, 4'b0000, 0, 0, 0,   1, S_G, 2, lamps(2, C_GRN), 4'b0000);
    add("t2_dwell",        1, 4'b0000, 0, 0, 0,  50, S_G, 2, lamps(2, C_GRN), 4'b0000);
    // Max green while the active phase keeps requesting.
    add("t3_reset",        0, 4'b0000, 0, 0, 0,   1, S_G, 0, lamps(0, C_GRN), 4'b0000);
    add("t3_req01",        1, 4'b0011, 0, 0, 0,   1, S_G, 0, lamps(0, C_GRN), 4'b0010);
    add("t3_hold",         1, 4'b0001, 0, 0, 0,  48, S_G, 0, lamps(0, C_GRN), 4'b0010);
    add("t3_yellow",       1, 4'b0001, 0, 0, 0,   1, S_Y, 0, lamps(0, C_YEL), 4'b0010);
    add("t3_pend0",        1, 4'b0001, 0, 0, 0,   1, S_Y, 0, lamps(0, C_YEL), 4'b0011);
    add("t3_allred",       1, 4'b0001, 0, 0, 0,   9, S_A, 0, L_ALL_RED,       4'b0011);
    add("t3_green1",       1, 4'b0001, 0, 0, 0,   5, S_G, 1, lamps(1, C_GRN), 4'b0001);
    // Round-robin wrap from phase 3.
    add("t4_reset",        0, 4'b0000, 0, 0, 0,   1, S_G, 0, lamps(0, C_GRN), 4'b0000);
    add("t4_req3",         1, 4'b1000, 0, 0, 0,   1, S_G, 0, lamps(0, C_GRN), 4'b1000);
    add("t4_yellow0",      1, 4'b0000, 0, 0, 0,   9, S_Y, 0, lamps(0, C_YEL), 4'b1000);
    add("t4_req02",        1, 4'b0101, 0, 0, 0,   1, S_Y, 0, lamps(0, C_YEL), 4'b1101);
    add("t4_green3",       1, 4'b0000, 0, 0, 0,  14, S_G, 3, lamps(3, C_GRN), 4'b0101);
    add("t4_yellow3",      1, 4'b0000, 0, 0, 0,  10, S_Y, 3, lamps(3, C_YEL), 4'b0101);
    add("t4_green0_wrap",  1, 4'b0000, 0, 0, 0,  15, S_G, 0, lamps(0, C_GRN), 4'b0100);
    add("t4_yellow0b",     1, 4'b0000, 0, 0, 0,  10, S_Y, 0, lamps(0, C_YEL), 4'b0100);
    add("t4_green2",       1, 4'b0000, 0, 0, 0,  15, S_G, 2, lamps(2, C_GRN), 4'b0000);
    // Preemption to phase 3 during early green.
    add("t5_reset",        0, 4'b0000, 0, 0, 0,   1, S_G, 0, lamps(0, C_GRN), 4'b0000);
    add("t5_cnt2",         1, 4'b0000, 0, 0, 0,   2, S_G, 0, lamps(0, C_GRN), 4'b0000);
    add("t5_preempt",      1, 4'b0000, 1, 3, 0,   1, S_Y, 0, lamps(0, C_YEL), 4'b0000);
    add("t5_yellow_end",   1, 4'b0000, 1, 3, 0,   9, S_Y, 0, lamps(0, C_YEL), 4'b0000);
    add("t5_allred",       1, 4'b0000, 1, 3, 0,   1, S_A, 0, L_ALL_RED,       4'b0000);
    add("t5_allred_end",   1, 4'b0000, 1, 3, 0,   4, S_A, 0, L_ALL_RED,       4'b0000);
    add("t5_green3",       1, 4'b0000, 1, 3, 0,   1, S_G, 3, lamps(3, C_GRN), 4'b0000);
    add("t5_req1",         1, 4'b0010, 1, 3, 0,   1, S_G, 3, lamps(3, C_GRN), 4'b0010);
    add("t5_hold",         1, 4'b0000, 1, 3, 0,  99, S_G, 3, lamps(3, C_GRN), 4'b0010);
    add("t5_release",      1, 4'b0000, 0, 0, 0,   1, S_Y, 3, lamps(3, C_YEL), 4'b0010);
    add("t5_green1",       1, 4'b0000, 0, 0, 0,  15, S_G, 1, lamps(1, C_GRN), 4'b0000);
    // Night flash entry/exit, then reset in the middle of yellow.
    add("t6_reset",        0, 4'b0000, 0, 0, 0,   1, S_G, 0, lamps(0, C_GRN), 4'b0000);
    add("t6_flash_green",  1, 4'b0000, 0, 0, 1,   9, S_G, 0, lamps(0, C_GRN), 4'b0000);
    add("t6_flash_yellow", 1, 4'b0000, 0, 0, 1,   1, S_Y, 0, lamps(0, C_YEL), 4'b0000);
    add("t6_flash_allred", 1, 4'b0000, 0, 0, 1,  10, S_A, 0, L_ALL_RED,       4'b0000);
    add("t6_flash_on",     1, 4'b0000, 0, 0, 1,   5, S_F, 0, L_FLASH_ON,      4'b0000);
    add("t6_flash_on_end", 1, 4'b0000, 0, 0, 1,   3, S_F, 0, L_FLASH_ON,      4'b0000);
    add("t6_flash_off",    1, 4'b0000, 0, 0, 1,   1, S_F, 0, L_FLASH_OFF,     4'b0000);
    add("t6_flash_req2",   1, 4'b0100, 0, 0, 1,   1, S_F, 0, L_FLASH_OFF,     4'b0100);
    add("t6_flash_off_end",1, 4'b0000, 0, 0, 1,   2, S_F, 0, L_FLASH_OFF,     4'b0100);
    add("t6_flash_on2",    1, 4'b0000, 0, 0, 1,   1, S_F, 0, L_FLASH_ON,      4'b0100);
    add("t6_exit",         1, 4'b0000, 0, 0, 0,   1, S_A, 0, L_ALL_RED,       4'b0100);
    add("t6_exit_end",     1, 4'b0000, 0, 0, 0,   4, S_A, 0, L_ALL_RED,       4'b0100);
    add("t6_green0",       1, 4'b0000, 0, 0, 0,   1, S_G, 0, lamps(0, C_GRN), 4'b0100);
    add("t6_yellow",       1, 4'b0000, 0, 0, 0,  10, S_Y, 0, lamps(0, C_YEL), 4'b0100);
    add("t6_rst_mid",      0, 4'b0000, 0, 0, 0,   1, S_G, 0, L_ALL_RED ^ 12'h005, 4'b0000);
    // Preemption out of flash, then flash resumes after release.
    add("fp_reset",        0, 4'b0000, 0, 0, 0,   1, S_G, 0, lamps(0, C_GRN), 4'b0000);
    add("fp_flash",        1, 4'b0000, 0, 0, 1,  25, S_F, 0, L_FLASH_ON,      4'b0000);
    add("fp_preempt",      1, 4'b0000, 1, 2, 1,   1, S_A, 0, L_ALL_RED,       4'b0000);
    add("fp_green2",       1, 4'b0000, 1, 2, 1,   5, S_G, 2, lamps(2, C_GRN), 4'b0000);
    add("fp_hold",         1, 4'b0000, 1, 2, 1,  20, S_G, 2, lamps(2, C_GRN), 4'b0000);
    add("fp_release",      1, 4'b0000, 0, 0, 1,   1, S_Y, 2, lamps(2, C_YEL), 4'b0000);
    add("fp_reflash",      1, 4'b0000, 0, 0, 1,  15, S_F, 2, L_FLASH_ON,      4'b0000);
    // Request racing the green entry of its own phase.
    add("race_reset",      0, 4'b0000, 0, 0, 0,   1, S_G, 0, lamps(0, C_GRN), 4'b0000);
    add("race_req1",       1, 4'b0010, 0, 0, 0,   1, S_G, 0, lamps(0, C_GRN), 4'b0010);
    add("race_wait",       1, 4'b0000, 0, 0, 0,  23, S_A, 0, L_ALL_RED,       4'b0010);
    add("race_clear",      1, 4'b0010, 0, 0, 0,   1, S_G, 1, lamps(1, C_GRN), 4'b0000);
    add("race_mask",       1, 4'b0010, 0, 0, 0,   1, S_G, 1, lamps(1, C_GRN), 4'b0000);
    // Timer saturation: a wrapping timer would restart min green.
    add("sat_reset",       0, 4'b0000, 0, 0, 0,   1, S_G, 0, lamps(0, C_GRN), 4'b0000);
    add("sat_idle",        1, 4'b0000, 0, 0, 0, 256, S_G, 0, lamps(0, C_GRN), 4'b0000);
    add("sat_req1",        1, 4'b0010, 0, 0, 0,   1, S_G, 0, lamps(0, C_GRN), 4'b0010);
    add("sat_yellow",      1, 4'b0000, 0, 0, 0,   1, S_Y, 0, lamps(0, C_YEL), 4'b0010);

    foreach (vecs[i]) begin
      rst           = vecs[i].rst;
      req           = vecs[i].req;
      preempt       = vecs[i].pre;
      preempt_phase = vecs[i].pph;
      flash_mode    = vecs[i].flash;
      step(vecs[i].steps);
      check({vecs[i].name, ".state"},   32'(ctrl_state),   32'(vecs[i].st));
      check({vecs[i].name, ".phase"},   32'(active_phase), 32'(vecs[i].ph));
      check({vecs[i].name, ".lights"},  32'(lights),       32'(vecs[i].lt));
      check({vecs[i].name, ".pending"}, 32'(pending),      32'(vecs[i].pend));
    end

    // Flash cadence cycle by cycle: 4 cycles on, 4 off, starting on.
    rst = 1'b0; req = '0; preempt = 1'b0; flash_mode = 1'b0;
    step(1);
    rst = 1'b1; flash_mode = 1'b1;
    step(25);
    check("flash_seq.state", 32'(ctrl_state), 32'(S_F));
    for (int i = 0; i < 16; i++) begin
      check($sformatf("flash_seq.lights[%0d]", i), 32'(lights),
            32'((((i / 4) % 2) == 0) ? L_FLASH_ON : L_FLASH_OFF));
      step(1);
    end
    flash_mode = 1'b0;
    step(6);
    check("flash_seq.exit_green", 32'(lights), 32'(lamps(0, C_GRN)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
